// File: rtl/stage5_field_extract_pipe_pkg.sv
// Shared constants for the stage-5 field extractor: message layout, mux code, default value.
package stage5_field_extract_pipe_pkg;

  localparam int unsigned MAX_MESSAGE_BITS          = 32;
  localparam int unsigned MESSAGE_MUX_CONTROL_WIDTH = 3;
  localparam int unsigned MESSAGE_MUX_D             = 5;
  localparam int unsigned DEFAUT_INFOR              = 32'h0000_01E7;
  localparam int unsigned D_OIV4_B                  = 15;
  localparam int unsigned D_OIV4_E                  = 8;
  localparam int unsigned FIELD_CNT_WIDTH           = 16;

endpackage

// File: rtl/stage5_field_extract_pipe_if.sv
// Lane-bundled handshake bus between the stage-4 classifier, the extractor and stage-6 consumers.
interface stage5_field_extract_pipe_if #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned MSG_BITS = 32,
  parameter int unsigned CTRL_W   = 3,
  parameter int unsigned FW       = 8,
  parameter int unsigned CNT_W    = 16
);
  logic                       message_en;
  logic                       cnt_clr;
  logic [NUM_CH-1:0]          msg_valid;
  logic [NUM_CH-1:0]          msg_ready;
  logic [NUM_CH*MSG_BITS-1:0] message_bus;
  logic [NUM_CH*CTRL_W-1:0]   mux_ctrl_bus;
  logic [NUM_CH-1:0]          field_valid;
  logic [NUM_CH-1:0]          field_ready;
  logic [NUM_CH*FW-1:0]       field_bus;
  logic [NUM_CH-1:0]          field_hit;
  logic [NUM_CH*CNT_W-1:0]    match_cnt_bus;

  // Extractor view
  modport slave (
    input  message_en, cnt_clr, msg_valid, message_bus, mux_ctrl_bus, field_ready,
    output msg_ready, field_valid, field_bus, field_hit, match_cnt_bus
  );

  // Producer/consumer view
  modport master (
    output message_en, cnt_clr, msg_valid, message_bus, mux_ctrl_bus, field_ready,
    input  msg_ready, field_valid, field_bus, field_hit, match_cnt_bus
  );
endinterface

// File: rtl/stage5_field_lane.sv
// One extractor lane: hit decision, 2-entry output skid (out + skid) and saturating match counter.
module stage5_field_lane
  import stage5_field_extract_pipe_pkg::*;
#(
  parameter int unsigned FW          = D_OIV4_B - D_OIV4_E + 1,
  parameter int unsigned CTRL_W      = MESSAGE_MUX_CONTROL_WIDTH,
  parameter int unsigned MATCH_CODE  = MESSAGE_MUX_D,
  parameter int unsigned DEFAULT_VAL = DEFAUT_INFOR,
  parameter int unsigned CNT_W       = FIELD_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              message_en_i,
  input  logic              cnt_clr_i,
  input  logic              msg_valid_i,
  input  logic [FW-1:0]     slice_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              msg_ready_o,
  input  logic              field_ready_i,
  output logic              field_valid_o,
  output logic [FW-1:0]     field_o,
  output logic              field_hit_o,
  output logic [CNT_W-1:0]  match_cnt_o
);

  logic              ready_q, ready_d;
  logic              out_valid_q, out_valid_d;
  logic [FW-1:0]     out_data_q, out_data_d;
  logic              out_hit_q, out_hit_d;
  logic              skid_valid_q, skid_valid_d;
  logic [FW-1:0]     skid_data_q, skid_data_d;
  logic              skid_hit_q, skid_hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept_c, pop_c, hit_c;
  logic [FW-1:0]     beat_data_c;

  // Next-state: pop frees the head (refilled from skid), accept lands in head when it is free
  always_comb begin
    ready_d      = ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_hit_d    = out_hit_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_hit_d   = skid_hit_q;
    cnt_d        = cnt_q;

    accept_c    = msg_valid_i & ready_q;
    pop_c       = out_valid_q & field_ready_i;
    hit_c       = message_en_i & (ctrl_i == CTRL_W'(MATCH_CODE));
    beat_data_c = hit_c ? slice_i : FW'(DEFAULT_VAL);

    if (pop_c) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_hit_d    = skid_hit_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // ready_q=0 whenever skid is full, so accept never collides with a skid-to-head move
    if (accept_c) begin
      if (!out_valid_q || pop_c) begin
        out_valid_d = 1'b1;
        out_data_d  = beat_data_c;
        out_hit_d   = hit_c;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = beat_data_c;
        skid_hit_d   = hit_c;
      end
    end

    ready_d = ~skid_valid_d;

    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (accept_c && hit_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= FW'(DEFAULT_VAL);
      out_hit_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= FW'(DEFAULT_VAL);
      skid_hit_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_hit_q    <= out_hit_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_hit_q   <= skid_hit_d;
      cnt_q        <= cnt_d;
    end
  end

  assign msg_ready_o   = ready_q;
  assign field_valid_o = out_valid_q;
  assign field_o       = out_data_q;
  assign field_hit_o   = out_hit_q;
  assign match_cnt_o   = cnt_q;

endmodule

// File: rtl/stage5_field_extract_pipe.sv
// Stage-5 field extractor: NUM_CH independent lanes; the top only slices the lane buses.
module stage5_field_extract_pipe
  import stage5_field_extract_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned MSG_BITS    = MAX_MESSAGE_BITS,
  parameter int unsigned CTRL_W      = MESSAGE_MUX_CONTROL_WIDTH,
  parameter int unsigned FIELD_MSB   = D_OIV4_B,
  parameter int unsigned FIELD_LSB   = D_OIV4_E,
  parameter int unsigned MATCH_CODE  = MESSAGE_MUX_D,
  parameter int unsigned DEFAULT_VAL = DEFAUT_INFOR,
  parameter int unsigned CNT_W       = FIELD_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  stage5_field_extract_pipe_if.slave    pipe_if
);

  localparam int unsigned FW = FIELD_MSB - FIELD_LSB + 1;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_lane
    stage5_field_lane #(
      .FW          (FW),
      .CTRL_W      (CTRL_W),
      .MATCH_CODE  (MATCH_CODE),
      .DEFAULT_VAL (DEFAULT_VAL),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .message_en_i  (pipe_if.message_en),
      .cnt_clr_i     (pipe_if.cnt_clr),
      .msg_valid_i   (pipe_if.msg_valid[i]),
      .slice_i       (pipe_if.message_bus[i*MSG_BITS + FIELD_LSB +: FW]),
      .ctrl_i        (pipe_if.mux_ctrl_bus[i*CTRL_W +: CTRL_W]),
      .msg_ready_o   (pipe_if.msg_ready[i]),
      .field_ready_i (pipe_if.field_ready[i]),
      .field_valid_o (pipe_if.field_valid[i]),
      .field_o       (pipe_if.field_bus[i*FW +: FW]),
      .field_hit_o   (pipe_if.field_hit[i]),
      .match_cnt_o   (pipe_if.match_cnt_bus[i*CNT_W +: CNT_W])
    );
  end

endmodule
